// File: rtl/act_quant_pkg.sv
// act_quant_pkg: shared types and default widths for the activation quantizer.
//   act_state_e  vector-tracking FSM states (IDLE, ACTIVE)
//   ACT_IN_W     default accumulator input width
//   ACT_OUT_W    default quantized output width
//   ACT_SHIFT_W  width of the per-element right-shift amount
package act_quant_pkg;

    localparam int unsigned ACT_IN_W    = 12;
    localparam int unsigned ACT_OUT_W   = 8;
    localparam int unsigned ACT_SHIFT_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } act_state_e;

endpackage

// File: rtl/act_fifo.sv
// act_fifo: synchronous FIFO holding quantized activations and their last flag.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset (empties the FIFO)
//   wr_en_i       push wr_data_i (ignored when full)
//   wr_data_i     entry to push
//   rd_en_i       pop the head (ignored when empty)
//   rd_data_o     current head entry
//   empty_o       no entries stored
//   count_o       number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module act_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_fire;
    logic             rd_fire;

    assign wr_fire = wr_en_i && (count_q != CNT_W'(DEPTH));
    assign rd_fire = rd_en_i && (count_q != CNT_W'(0));

    // Pointer and occupancy update; simultaneous push and pop keep occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == CNT_W'(0));
    assign count_o   = count_q;

endmodule

// File: rtl/act_quant.sv
// act_quant: shifts, clamps and buffers accumulator sums into OUT_W-bit
// activations with vector framing and saturation statistics.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_data, in_last, shift sampled on transfer
//   out_valid/out_ready output handshake; out_data, out_last from FIFO head
//   sat_count           saturating count of clamped elements
//   frames_done         wrapping count of delivered vectors
//   busy                vector in progress or output FIFO not empty
// Build option: define ACT_QUANT_RELU_EN to clamp to [0, max] with negatives
// forced to zero (not counted as saturation).
module act_quant
    import act_quant_pkg::*;
#(
    parameter int unsigned IN_W  = ACT_IN_W,
    parameter int unsigned OUT_W = ACT_OUT_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   in_last,
    input  logic [ACT_SHIFT_W-1:0] shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_last,
    output logic [7:0]             sat_count,
    output logic [7:0]             frames_done,
    output logic                   busy
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned FIFO_W = OUT_W + 1;
    localparam logic signed [IN_W-1:0] Q_MAX = IN_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] Q_MIN = ~Q_MAX;

    act_state_e             state_q, state_d;
    logic                   s1_valid_q, s1_valid_d;
    logic signed [IN_W-1:0] s1_data_q, s1_data_d;
    logic                   s1_last_q, s1_last_d;
    logic [7:0]             sat_q, sat_d;
    logic [7:0]             frames_q, frames_d;

    logic                   in_fire;
    logic                   out_fire;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [FIFO_W-1:0]      fifo_rdata;
    logic [OUT_W-1:0]       clamp_c;
    logic                   sat_c;

    // Admission counts the stage-1 element so it always finds a free slot.
    assign in_ready  = !rst && ((32'(fifo_count) + 32'(s1_valid_q)) < DEPTH);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = !rst && !fifo_empty;
    assign out_fire  = out_valid && out_ready;

    // Stage 2: clamp the shifted value into the output range.
    always_comb begin
        clamp_c = s1_data_q[OUT_W-1:0];
        sat_c   = 1'b0;
`ifdef ACT_QUANT_RELU_EN
        if (s1_data_q[IN_W-1]) begin
            clamp_c = '0;
        end else if (s1_data_q > Q_MAX) begin
            clamp_c = Q_MAX[OUT_W-1:0];
            sat_c   = 1'b1;
        end
`else
        if (s1_data_q > Q_MAX) begin
            clamp_c = Q_MAX[OUT_W-1:0];
            sat_c   = 1'b1;
        end else if (s1_data_q < Q_MIN) begin
            clamp_c = Q_MIN[OUT_W-1:0];
            sat_c   = 1'b1;
        end
`endif
    end

    // Next state: stage-1 load, vector FSM and statistics counters.
    always_comb begin
        state_d    = state_q;
        s1_valid_d = in_fire;
        s1_data_d  = s1_data_q;
        s1_last_d  = s1_last_q;
        sat_d      = sat_q;
        frames_d   = frames_q;

        if (in_fire) begin
            s1_data_d = $signed(in_data) >>> shift;
            s1_last_d = in_last;
        end

        case (state_q)
            IDLE:    if (in_fire && !in_last) state_d = ACTIVE;
            ACTIVE:  if (in_fire && in_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (s1_valid_q && sat_c && (sat_q != 8'hFF)) begin
            sat_d = sat_q + 8'd1;
        end
        if (out_fire && fifo_rdata[OUT_W]) begin
            frames_d = frames_q + 8'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_last_q  <= 1'b0;
            sat_q      <= '0;
            frames_q   <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_last_q  <= s1_last_d;
            sat_q      <= sat_d;
            frames_q   <= frames_d;
        end
    end

    act_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (s1_valid_q),
        .wr_data_i ({s1_last_q, clamp_c}),
        .rd_en_i   (out_fire),
        .rd_data_o (fifo_rdata),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Head outputs are forced quiet while reset is held.
    assign out_data    = rst ? '0 : fifo_rdata[OUT_W-1:0];
    assign out_last    = !rst && fifo_rdata[OUT_W];
    assign sat_count   = sat_q;
    assign frames_done = frames_q;
    assign busy        = !rst && ((state_q == ACTIVE) || !fifo_empty);

endmodule
